// File: rtl/fp_pkg.sv
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared FP32 field widths, bias, operand struct and FSM encoding
//            for the floating-point accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = FRAC_W + 1;
    localparam int ALN_W   = MANT_W + 1;
    localparam int SUM_W   = ALN_W + 1;
    localparam int LZC_W   = 5;
    localparam int EXPS_W  = 10;
    localparam int FP_BIAS = 127;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        OUT   = 3'd4
    } state_e;

    // Exponent field 0 is exact zero, so its hidden bit and fraction vanish.
    function automatic logic [MANT_W-1:0] hidden_mant(input logic [EXP_W-1:0]  e,
                                                      input logic [FRAC_W-1:0] f);
        return (e == '0) ? '0 : {1'b1, f};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_lzc.sv
// ============================================================================
// Module   : fp_lzc
// Brief    : Combinational 24-bit leading-zero counter (all-zero input -> 24).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_lzc
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0] data_i,
    output logic [LZC_W-1:0]  count_o
);

    // Scanning upward lets the highest set bit write last.
    always_comb begin
        count_o = LZC_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (data_i[i]) begin
                count_o = LZC_W'(MANT_W - 1 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_acc.sv
// ============================================================================
// Module   : fp_acc
// Brief    : Multi-cycle FP32 accumulator (ALIGN/ADD/NORM) with valid/ready
//            streaming; optional exponent saturation via FP_ACC_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_acc
    import fp_pkg::*;
#(
    parameter int BIAS = FP_BIAS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] out_count
);

    localparam logic signed [EXPS_W-1:0] BIAS_S = EXPS_W'(BIAS);
`ifdef FP_ACC_SAT_EN
    localparam logic signed [EXPS_W-1:0] EXP_MAX_S = EXPS_W'(2 * BIAS + 1);
`endif

    state_e              state_q, state_d;
    fp32_t               acc_q, acc_d;
    logic [15:0]         count_q, count_d;
    fp32_t               op_q;
    logic                last_q;

    logic [ALN_W-1:0]    big_mant_q, small_mant_q;
    logic [EXP_W-1:0]    big_exp_q;
    logic                big_sign_q;
    logic                sub_q;
    logic                bypass_q;
    logic [SUM_W-1:0]    sum_q;

    logic                w_accept;
    logic                w_swap;
    fp32_t               w_big, w_small;
    logic [EXP_W-1:0]    w_diff;
    logic [ALN_W-1:0]    w_small_al;
    logic [SUM_W-1:0]    w_sum;

    logic [LZC_W-1:0]    w_lzc;
    logic [ALN_W-1:0]    w_norm;
    logic [ALN_W-1:0]    w_round;
    logic [FRAC_W-1:0]   w_frac;
    logic signed [EXPS_W-1:0] w_exp_unb, w_exp_norm, w_exp_fin, w_exp_biased;
    fp32_t               w_result;
`ifndef FP_ACC_SAT_EN
    logic                w_exp_hi_unused;
`endif

    assign w_accept = in_valid && (state_q == IDLE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = ALIGN;
            ALIGN:                  state_d = ADD;
            ADD:                    state_d = NORM;
            NORM:                   state_d = last_q ? OUT : IDLE;
            OUT:     if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == OUT);
    end

    assign out_data  = acc_q;
    assign out_count = count_q;

    // ---------------- ALIGN: order by magnitude, shift the smaller ----------------
    always_comb begin
        w_swap     = {op_q.exp,  hidden_mant(op_q.exp,  op_q.frac)} >
                     {acc_q.exp, hidden_mant(acc_q.exp, acc_q.frac)};
        w_big      = w_swap ? op_q  : acc_q;
        w_small    = w_swap ? acc_q : op_q;
        w_diff     = w_big.exp - w_small.exp;
        w_small_al = (w_diff > EXP_W'(MANT_W)) ? '0 :
                     ({hidden_mant(w_small.exp, w_small.frac), 1'b0} >> w_diff);
    end

    // ---------------- ADD: magnitudes already ordered, no underflow ----------------
    always_comb begin
        if (sub_q) begin
            w_sum = {1'b0, big_mant_q} - {1'b0, small_mant_q};
        end else begin
            w_sum = {1'b0, big_mant_q} + {1'b0, small_mant_q};
        end
    end

    // ---------------- NORM ----------------
    fp_lzc u_lzc (
        .data_i  (sum_q[ALN_W-1:1]),
        .count_o (w_lzc)
    );

    always_comb begin
        w_exp_unb = $signed({{(EXPS_W-EXP_W){1'b0}}, big_exp_q}) - BIAS_S;
        if (sum_q[SUM_W-1]) begin
            w_norm     = sum_q[SUM_W-1:1];
            w_exp_norm = w_exp_unb + 10'sd1;
        end else begin
            w_norm     = sum_q[ALN_W-1:0] << w_lzc;
            w_exp_norm = w_exp_unb - $signed({{(EXPS_W-LZC_W){1'b0}}, w_lzc});
        end
        // Half-up on the single guard bit; an all-ones mantissa carries out.
        w_round      = {1'b0, w_norm[ALN_W-1:1]} + {{(ALN_W-1){1'b0}}, w_norm[0]};
        w_frac       = w_round[MANT_W] ? w_round[MANT_W-1:1] : w_round[FRAC_W-1:0];
        w_exp_fin    = w_round[MANT_W] ? (w_exp_norm + 10'sd1) : w_exp_norm;
        w_exp_biased = w_exp_fin + BIAS_S;
`ifdef FP_ACC_SAT_EN
        if (w_exp_biased >= EXP_MAX_S) begin
            w_result = '{sign: big_sign_q, exp: EXP_W'(2 * BIAS), frac: '1};
        end else if (w_exp_biased <= 10'sd0) begin
            w_result = '0;
        end else begin
            w_result = '{sign: big_sign_q, exp: w_exp_biased[EXP_W-1:0], frac: w_frac};
        end
`else
        w_exp_hi_unused = |w_exp_biased[EXPS_W-1:EXP_W];
        w_result        = '{sign: big_sign_q, exp: w_exp_biased[EXP_W-1:0], frac: w_frac};
`endif
        if (sum_q == '0) begin
            w_result = '0;
        end
    end

    // ---------------- accumulator / count next state ----------------
    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        if (w_accept) begin
            count_d = count_q + 16'd1;
        end
        if ((state_q == NORM) && !bypass_q) begin
            acc_d = w_result;
        end
        if ((state_q == OUT) && out_ready) begin
            acc_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            count_q      <= '0;
            op_q         <= '0;
            last_q       <= 1'b0;
            big_mant_q   <= '0;
            small_mant_q <= '0;
            big_exp_q    <= '0;
            big_sign_q   <= 1'b0;
            sub_q        <= 1'b0;
            bypass_q     <= 1'b0;
            sum_q        <= '0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            if (w_accept) begin
                op_q   <= in_data;
                last_q <= in_last;
            end
            if (state_q == ALIGN) begin
                big_mant_q   <= {hidden_mant(w_big.exp, w_big.frac), 1'b0};
                small_mant_q <= w_small_al;
                big_exp_q    <= w_big.exp;
                big_sign_q   <= w_big.sign;
                sub_q        <= w_big.sign ^ w_small.sign;
                // A zero operand must leave the accumulator bit-identical.
                bypass_q     <= (op_q.exp == '0);
            end
            if (state_q == ADD) begin
                sum_q <= w_sum;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_acc.sv
// ============================================================================
// Module   : tb_fp_acc
// Brief    : Self-checking bench for fp_acc: directed cases plus random streams
//            scored against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_acc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_count;

    fp_acc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    typedef struct {
        logic [31:0] data;
        logic [15:0] cnt;
    } res_t;

    res_t        exp_q[$];
    logic [31:0] m_acc;
    logic [15:0] m_cnt;
    int          n_pass;
    int          n_total;
    int          ready_mode;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    endfunction

    // Reference sum built from integer mantissas scaled by two (one guard bit).
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, eg, es, d, e;
        longint ma, mb, mg, ms, v, m;
        logic   sa, sb, sg;
        if (b[30:23] == 8'd0) return a;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = (ea == 0) ? 64'd0 : longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        sa = a[31];
        sb = b[31];
        if (eb > ea || (eb == ea && mb > ma)) begin
            eg = eb; mg = mb; sg = sb; es = ea; ms = ma;
        end else begin
            eg = ea; mg = ma; sg = sa; es = eb; ms = mb;
        end
        d = eg - es;
        v = (d > 24) ? 64'd0 : ((ms * 2) >> d);
        v = (sa == sb) ? (mg * 2 + v) : (mg * 2 - v);
        if (v == 0) return 32'h0;
        e = eg;
        if (v >= (64'd1 << 25)) begin
            v = v / 2;
            e++;
        end
        while (v < (64'd1 << 24)) begin
            v = v * 2;
            e--;
        end
        m = v / 2 + (v % 2);
        if (m == (64'd1 << 24)) begin
            m = m / 2;
            e++;
        end
`ifdef FP_ACC_SAT_EN
        if (e >= 255) return {sg, 31'h7F7FFFFF};
        if (e <= 0) return 32'h0;
`endif
        return {sg, e[7:0], m[22:0]};
    endfunction

    function automatic void model_accept(input logic [31:0] d, input logic l);
        m_acc = model_add(m_acc, d);
        m_cnt = m_cnt + 16'd1;
        if (l) begin
            exp_q.push_back('{data: m_acc, cnt: m_cnt});
            m_acc = 32'h0;
            m_cnt = 16'h0;
        end
    endfunction

    function automatic void model_reset();
        m_acc = 32'h0;
        m_cnt = 16'h0;
        exp_q.delete();
    endfunction

    // Output consumer: drives out_ready just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard compare on every cycle a sum is presented.
    always @(negedge clk) begin
        if (rst !== 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("sb_data", out_data, exp_q[0].data);
                check("sb_count", 32'(out_count), 32'(exp_q[0].cnt));
                check("sb_in_ready_busy", 32'(in_ready), 32'd0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Called at posedge+#1; returns at accepting edge +#1.
    task automatic send(input logic [31:0] d, input logic l);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        else model_accept(d, l);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom);
    endtask

    task automatic expect_result(input string nm, input logic [31:0] d, input logic [15:0] c);
        repeat (3) @(negedge clk);
        check({nm, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({nm, "_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_data"}, out_data, d);
        check({nm, "_count"}, 32'(out_count), 32'(c));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] gen_val();
        int k;
        k = $urandom_range(0, 15);
        if (k == 0) return {1'($urandom), 8'h00, 23'($urandom)};
        if (k == 1) return $urandom;
        if (k == 2 && m_acc[30:23] != 8'd0) return m_acc ^ 32'h8000_0000;
        return {1'($urandom), 8'($urandom_range(118, 136)), 23'($urandom)};
    endfunction

    initial begin
        time t0, t1, t2;
        n_pass     = 0;
        n_total    = 0;
        ready_mode = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 32'h0;
        in_last    = 1'b0;
        model_reset();
        idle_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_count", 32'(out_count), 32'd0);
        @(posedge clk);
        #1;

        // 1 + 2 + 3, back to back
        send(32'h3F80_0000, 1'b0);
        t0 = $time;
        send(32'h4000_0000, 1'b0);
        t1 = $time;
        send(32'h4040_0000, 1'b1);
        t2 = $time;
        check("throughput_1", 32'(t1 - t0), 32'd40);
        check("throughput_2", 32'(t2 - t1), 32'd40);
        expect_result("sum123", 32'h40C0_0000, 16'd3);

        send(32'h40A0_0000, 1'b0);
        send(32'hC0A0_0000, 1'b1);
        expect_result("cancel", 32'h0000_0000, 16'd2);

        send(32'h4B80_0000, 1'b0);
        send(32'h3F80_0000, 1'b1);
        expect_result("guard_round", 32'h4B80_0001, 16'd2);

        // zero operand with nonzero fraction is flushed and leaves acc intact
        send(32'h4040_0000, 1'b0);
        send(32'h0012_3456, 1'b1);
        expect_result("zero_flush", 32'h4040_0000, 16'd2);

        // consumer stall
        @(negedge clk);
        ready_mode = 2;
        @(posedge clk);
        #1;
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        send(32'h4040_0000, 1'b1);
        expect_result("stall", 32'h40C0_0000, 16'd3);
        repeat (5) begin
            @(negedge clk);
            check("stall_hold_valid", 32'(out_valid), 32'd1);
            check("stall_hold_data", out_data, 32'h40C0_0000);
            check("stall_hold_count", 32'(out_count), 32'd3);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        ready_mode = 0;
        idle_cycles(2);
        send(32'h3F80_0000, 1'b1);
        expect_result("after_stall", 32'h3F80_0000, 16'd1);

        // reset while in ADD discards the element
        send(32'h4040_0000, 1'b0);
        idle_cycles(1);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, 32'h0);
        check("midrst_out_count", 32'(out_count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(32'h4000_0000, 1'b1);
        expect_result("after_rst", 32'h4000_0000, 16'd1);

        send(32'h7F7F_FFFF, 1'b0);
        send(32'h7F7F_FFFF, 1'b1);
`ifdef FP_ACC_SAT_EN
        expect_result("exp_max", 32'h7F7F_FFFF, 16'd2);
`else
        expect_result("exp_max", 32'h7FFF_FFFF, 16'd2);
`endif

        // random streams against the model
        @(negedge clk);
        ready_mode = 1;
        @(posedge clk);
        #1;
        for (int s = 0; s < 80; s++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int e = 0; e < len; e++) begin
                idle_cycles($urandom_range(0, 2));
                send(gen_val(), (e == len - 1));
            end
        end
        @(negedge clk);
        ready_mode = 0;
        idle_cycles(20);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_acc.md
FP_ACC -- requirements
Module: fp_acc

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, in_data/in_last valid.
REQ-004 SHALL have port in_ready, output, 1, block accepts element this cycle.
REQ-005 SHALL have port in_data, input, 32, IEEE-754 single operand (multiplier product).
REQ-006 SHALL have port in_last, input, 1, element closes current sum.
REQ-007 SHALL have port out_valid, output, 1, sum available.
REQ-008 SHALL have port out_ready, input, 1, consumer takes sum.
REQ-009 SHALL have port out_data, output, 32, accumulated sum.
REQ-010 SHALL have port out_count, output, 16, elements in sum, wraps 0xFFFF->0x0000.
REQ-011 SHALL have parameter BIAS, default 127, exponent bias.

Function
REQ-012 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, OUT; in_ready = (state==IDLE).
REQ-013 SHALL accept an element on the edge where in_valid && in_ready; in_last sampled only then; IDLE->ALIGN->ADD->NORM, one edge each.
REQ-014 SHALL leave NORM to OUT if accepted element had in_last, else to IDLE with acc updated; throughput one element per 4 cycles.
REQ-015 SHALL assert out_valid on the 4th rising edge counting the accepting edge; out_data/out_count held stable while out_valid && !out_ready.
REQ-016 SHALL on out_valid && out_ready clear acc to 0x00000000 and count to 0, go IDLE.
REQ-017 SHALL treat exponent field 0 as exact zero (denormals flushed); zero operand leaves acc bit-identical.
REQ-018 SHALL treat exponent 255 as ordinary finite value (no Inf/NaN handling).
REQ-019 ALIGN SHALL select larger magnitude by {exp,mant}, right-shift smaller 24-bit hidden-bit mantissa by exponent difference keeping one guard bit; difference > 24 contributes zero.
REQ-020 ADD SHALL add if signs equal, else subtract smaller from larger; result sign = larger's sign; exact cancellation gives +0.
REQ-021 NORM SHALL: carry-out -> shift right 1, exp+1; else shift left by leading-zero count, exp-lzc; round half-up on guard bit; rounding carry renormalises.
REQ-022 SHALL compute exponent in 10-bit signed form before packing.
REQ-023 SHALL increment count on each accepted element.

Reset
REQ-024 SHALL on rst force state IDLE, acc 0, count 0, out_valid 0, out_data 0, out_count 0, in_ready 1 next cycle.
REQ-025 SHALL discard any in-flight element when rst asserted in any state, including OUT.

Configuration
REQ-026 SHALL with FP_ACC_SAT_EN defined clamp exponent >= 255 to magnitude 0x7F7FFFFF (sign kept) and flush exponent <= 0 to +0.
REQ-027 SHALL without FP_ACC_SAT_EN pack low 8 bits of computed exponent unchecked (wrap).

Structure
REQ-028 SHALL take FP32 field widths, BIAS constant, fp32 struct typedef and FSM state enum from shared package fp_pkg.
REQ-029 SHALL instantiate one sub-module fp_lzc (24-bit leading-zero counter, combinational) for NORM.

Verification
REQ-030 SHALL cover: 0x3F800000, 0x40000000, 0x40400000(last) -> out_data 0x40C00000, out_count 3.
REQ-031 SHALL cover: 0x40A00000, 0xC0A00000(last) -> out_data 0x00000000, out_count 2.
REQ-032 SHALL cover: 0x4B800000, 0x3F800000(last) -> out_data 0x4B800001 (guard round-up).
REQ-033 SHALL cover: out_ready low 5 cycles after out_valid -> out_data stable, in_ready 0; after handshake 0x3F800000(last) -> 0x3F800000, count 1.
REQ-034 SHALL cover: rst asserted in ADD -> all outputs 0; then 0x40000000(last) -> 0x40000000, count 1.
REQ-035 SHALL cover: 0x7F7FFFFF, 0x7F7FFFFF(last) -> 0x7F7FFFFF with FP_ACC_SAT_EN, 0x7FFFFFFF without.
